// File: rtl/raid_rebuild_scheduler_if.sv
// rtl/raid_rebuild_scheduler_if.sv - storage controller command port (strobes, address/data, done handshakes)
interface raid_rebuild_scheduler_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              wr_en_out;
    logic              rd_en_out;
    logic [ADDR_W-1:0] address_out;
    logic [DATA_W-1:0] write_data_out;
    logic              wr_done;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_en_out,
        output rd_en_out,
        output address_out,
        output write_data_out,
        input  wr_done,
        input  rd_done,
        input  rd_data
    );

    modport slave (
        input  wr_en_out,
        input  rd_en_out,
        input  address_out,
        input  write_data_out,
        output wr_done,
        output rd_done,
        output rd_data
    );
endinterface

// File: rtl/raid_rebuild_scheduler.sv
// rtl/raid_rebuild_scheduler.sv - arbitrates host ops and a background rebuild sweep onto one command port
module raid_rebuild_scheduler #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int HOST_BURST = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_wr_req,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rd_data,
    input  logic              rebuild_start,
    input  logic              rebuild_abort,
    output logic              rebuild_busy,
    output logic [ADDR_W-1:0] rebuild_addr,
    output logic              rebuild_done,
    output logic              timeout_err,
    raid_rebuild_scheduler_if.master ctrl
);
    typedef enum logic [2:0] {IDLE, H_WR, H_RD, RB_RD, RB_WR} state_t;

    localparam logic [3:0]        BURST_MAX = 4'(HOST_BURST);
    localparam logic [7:0]        TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    state_t            state, state_n;
    logic [3:0]        burst_cnt, burst_n;
    logic [7:0]        tmo_cnt, tmo_n;
    logic              abort_pend, abort_n;
    logic              busy_n, ack_n, done_n, terr_n;
    logic [ADDR_W-1:0] rb_addr_n;
    logic [DATA_W-1:0] hrd_n;
    logic              wr_en, wr_en_n, rd_en, rd_en_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic              abort_now, rb_pending, tmo_hit;

    assign ctrl.wr_en_out      = wr_en;
    assign ctrl.rd_en_out      = rd_en;
    assign ctrl.address_out    = addr_q;
    assign ctrl.write_data_out = wdata_q;

    always_comb begin
        state_n   = state;
        burst_n   = burst_cnt;
        tmo_n     = tmo_cnt;
        abort_n   = abort_pend | (rebuild_abort & rebuild_busy);
        busy_n    = rebuild_busy;
        rb_addr_n = rebuild_addr;
        ack_n     = 1'b0;
        done_n    = 1'b0;
        terr_n    = timeout_err;
        hrd_n     = host_rd_data;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        addr_n    = addr_q;
        wdata_n   = wdata_q;

        abort_now  = abort_pend | rebuild_abort;
        rb_pending = rebuild_busy & ~abort_now;
        tmo_hit    = (tmo_cnt == TMO_LAST);

        if (!rebuild_busy) begin
            burst_n = '0;
            if (rebuild_start) begin
                busy_n    = 1'b1;
                rb_addr_n = '0;
            end
        end

        case (state)
            IDLE: begin
                // No op in flight here, so a pending abort takes effect immediately.
                if (rebuild_busy && abort_now) begin
                    busy_n    = 1'b0;
                    rb_addr_n = '0;
                    abort_n   = 1'b0;
                end
                if (rb_pending && burst_cnt == BURST_MAX) begin
                    state_n = RB_RD;
                    rd_en_n = 1'b1;
                    addr_n  = rebuild_addr;
                    tmo_n   = '0;
                    burst_n = '0;
                end else if (host_wr_req) begin
                    state_n = H_WR;
                    wr_en_n = 1'b1;
                    addr_n  = host_addr;
                    wdata_n = host_wr_data;
                    tmo_n   = '0;
                    if (rebuild_busy) burst_n = burst_cnt + 4'd1;
                end else if (host_rd_req) begin
                    state_n = H_RD;
                    rd_en_n = 1'b1;
                    addr_n  = host_addr;
                    tmo_n   = '0;
                    if (rebuild_busy) burst_n = burst_cnt + 4'd1;
                end else if (rb_pending) begin
                    state_n = RB_RD;
                    rd_en_n = 1'b1;
                    addr_n  = rebuild_addr;
                    tmo_n   = '0;
                    burst_n = '0;
                end
            end
            H_WR: begin
                if (ctrl.wr_done) begin
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    terr_n  = 1'b1;
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 8'd1;
                end
            end
            H_RD: begin
                if (ctrl.rd_done) begin
                    hrd_n   = ctrl.rd_data;
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end else if (tmo_hit) begin
                    terr_n  = 1'b1;
                    ack_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 8'd1;
                end
            end
            RB_RD: begin
                // Write-back follows directly so no host op can slip between read and write.
                if (ctrl.rd_done) begin
                    wdata_n = ctrl.rd_data;
                    wr_en_n = 1'b1;
                    tmo_n   = '0;
                    state_n = RB_WR;
                end else if (tmo_hit) begin
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 8'd1;
                end
            end
            RB_WR: begin
                if (ctrl.wr_done) begin
                    state_n = IDLE;
                    if (abort_now) begin
                        busy_n    = 1'b0;
                        rb_addr_n = '0;
                        abort_n   = 1'b0;
                    end else if (rebuild_addr == ADDR_LAST) begin
                        done_n    = 1'b1;
                        busy_n    = 1'b0;
                        rb_addr_n = '0;
                    end else begin
                        rb_addr_n = rebuild_addr + ADDR_W'(1);
                    end
                end else if (tmo_hit) begin
                    terr_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            burst_cnt    <= '0;
            tmo_cnt      <= '0;
            abort_pend   <= 1'b0;
            rebuild_busy <= 1'b0;
            rebuild_addr <= '0;
            rebuild_done <= 1'b0;
            host_ack     <= 1'b0;
            host_rd_data <= '0;
            timeout_err  <= 1'b0;
            wr_en        <= 1'b0;
            rd_en        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state        <= state_n;
            burst_cnt    <= burst_n;
            tmo_cnt      <= tmo_n;
            abort_pend   <= abort_n;
            rebuild_busy <= busy_n;
            rebuild_addr <= rb_addr_n;
            rebuild_done <= done_n;
            host_ack     <= ack_n;
            host_rd_data <= hrd_n;
            timeout_err  <= terr_n;
            wr_en        <= wr_en_n;
            rd_en        <= rd_en_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
        end
    end
endmodule

// File: tb/tb_raid_rebuild_scheduler.sv
// tb/tb_raid_rebuild_scheduler.sv - directed self-checking bench for raid_rebuild_scheduler
module tb_raid_rebuild_scheduler;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic        host_wr_req = 1'b0, host_rd_req = 1'b0;
    logic [7:0]  host_addr = '0;
    logic [15:0] host_wr_data = '0;
    logic        host_ack;
    logic [15:0] host_rd_data;
    logic        rebuild_start = 1'b0, rebuild_abort = 1'b0;
    logic        rebuild_busy, rebuild_done, timeout_err;
    logic [7:0]  rebuild_addr;

    logic        auto_big = 1'b0;
    logic        m_wr_done = 1'b0, m_rd_done = 1'b0;
    logic [15:0] m_rd_data = '0;
    logic        a_wr_done = 1'b0, a_rd_done = 1'b0;
    logic [15:0] a_rd_data = '0;

    raid_rebuild_scheduler_if #(.ADDR_W(8), .DATA_W(16)) ifb ();
    assign ifb.wr_done = auto_big ? a_wr_done : m_wr_done;
    assign ifb.rd_done = auto_big ? a_rd_done : m_rd_done;
    assign ifb.rd_data = auto_big ? a_rd_data : m_rd_data;

    raid_rebuild_scheduler #(.ADDR_W(8), .DATA_W(16), .HOST_BURST(4), .TIMEOUT(255)) u_dut (
        .clk(clk), .reset(reset),
        .host_wr_req(host_wr_req), .host_rd_req(host_rd_req),
        .host_addr(host_addr), .host_wr_data(host_wr_data),
        .host_ack(host_ack), .host_rd_data(host_rd_data),
        .rebuild_start(rebuild_start), .rebuild_abort(rebuild_abort),
        .rebuild_busy(rebuild_busy), .rebuild_addr(rebuild_addr), .rebuild_done(rebuild_done),
        .timeout_err(timeout_err), .ctrl(ifb)
    );

    logic        s_rebuild_start = 1'b0;
    logic        s_host_ack, s_rebuild_busy, s_rebuild_done, s_timeout_err;
    logic [15:0] s_host_rd_data;
    logic [1:0]  s_rebuild_addr;
    logic        s_wr_done = 1'b0, s_rd_done = 1'b0;
    logic [15:0] s_rd_data = '0;

    raid_rebuild_scheduler_if #(.ADDR_W(2), .DATA_W(16)) ifs ();
    assign ifs.wr_done = s_wr_done;
    assign ifs.rd_done = s_rd_done;
    assign ifs.rd_data = s_rd_data;

    raid_rebuild_scheduler #(.ADDR_W(2), .DATA_W(16), .HOST_BURST(4), .TIMEOUT(255)) u_small (
        .clk(clk), .reset(reset),
        .host_wr_req(1'b0), .host_rd_req(1'b0),
        .host_addr(2'b00), .host_wr_data(16'h0000),
        .host_ack(s_host_ack), .host_rd_data(s_host_rd_data),
        .rebuild_start(s_rebuild_start), .rebuild_abort(1'b0),
        .rebuild_busy(s_rebuild_busy), .rebuild_addr(s_rebuild_addr), .rebuild_done(s_rebuild_done),
        .timeout_err(s_timeout_err), .ctrl(ifs)
    );

    // Controller model: answers every strobe within the same cycle it is seen.
    always @(negedge clk) begin
        a_wr_done = ifb.wr_en_out;
        a_rd_done = ifb.rd_en_out;
        a_rd_data = 16'hA000 + {8'h00, ifb.address_out};
        s_wr_done = ifs.wr_en_out;
        s_rd_done = ifs.rd_en_out;
        s_rd_data = 16'hC000 + {14'h0000, ifs.address_out};
    end

    logic [31:0] log_b[$];
    logic [31:0] log_s[$];
    int done_b = 0;
    int done_s = 0;
    always @(negedge clk) begin
        if (ifb.wr_en_out || ifb.rd_en_out)
            log_b.push_back({7'd0, ifb.wr_en_out, ifb.address_out, ifb.wr_en_out ? ifb.write_data_out : 16'h0000});
        if (ifs.wr_en_out || ifs.rd_en_out)
            log_s.push_back({7'd0, ifs.wr_en_out, 6'd0, ifs.address_out, ifs.wr_en_out ? ifs.write_data_out : 16'h0000});
        if (rebuild_done) done_b++;
        if (s_rebuild_done) done_s++;
    end

    function automatic logic [31:0] evb(input logic wr, input logic [7:0] a, input logic [15:0] d);
        return {7'd0, wr, a, d};
    endfunction

    function automatic logic [31:0] evs(input logic wr, input logic [1:0] a, input logic [15:0] d);
        return {7'd0, wr, 6'd0, a, d};
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({host_ack, rebuild_busy, rebuild_done, timeout_err, ifb.wr_en_out, ifb.rd_en_out} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000000",
                {host_ack, rebuild_busy, rebuild_done, timeout_err, ifb.wr_en_out, ifb.rd_en_out});
        end
        n_tests++;
        if ({rebuild_addr, ifb.address_out, ifb.write_data_out, host_rd_data} !== 48'h0) begin
            n_fail++; $display("FAIL reset_buses: got %h want 0",
                {rebuild_addr, ifb.address_out, ifb.write_data_out, host_rd_data});
        end
        n_tests++;
        if ({s_host_ack, s_rebuild_busy, s_timeout_err, s_rebuild_addr, s_host_rd_data} !== 21'h0) begin
            n_fail++; $display("FAIL reset_small: got %h want 0",
                {s_host_ack, s_rebuild_busy, s_timeout_err, s_rebuild_addr, s_host_rd_data});
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({host_ack, rebuild_busy, ifb.wr_en_out, ifb.rd_en_out} !== 4'b0) begin
            n_fail++; $display("FAIL reset_idle: got %b want 0000",
                {host_ack, rebuild_busy, ifb.wr_en_out, ifb.rd_en_out});
        end
    endtask

    task automatic test_host_write;
        @(negedge clk);
        host_addr = 8'h12; host_wr_data = 16'hBEEF; host_wr_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ifb.wr_en_out, ifb.rd_en_out, ifb.address_out, ifb.write_data_out} !== {2'b10, 8'h12, 16'hBEEF}) begin
            n_fail++; $display("FAIL wr_grant: got %h want %h",
                {ifb.wr_en_out, ifb.rd_en_out, ifb.address_out, ifb.write_data_out}, {2'b10, 8'h12, 16'hBEEF});
        end
        @(negedge clk);
        n_tests++;
        if ({ifb.wr_en_out, host_ack} !== 2'b00) begin
            n_fail++; $display("FAIL wr_strobe_len: got %b want 00", {ifb.wr_en_out, host_ack});
        end
        @(negedge clk);
        m_wr_done = 1'b1;
        @(negedge clk);
        m_wr_done = 1'b0;
        n_tests++;
        if ({host_ack, ifb.address_out} !== {1'b1, 8'h12}) begin
            n_fail++; $display("FAIL wr_ack: got %h want %h", {host_ack, ifb.address_out}, {1'b1, 8'h12});
        end
        host_wr_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({host_ack, ifb.wr_en_out} !== 2'b00) begin
            n_fail++; $display("FAIL wr_ack_pulse: got %b want 00", {host_ack, ifb.wr_en_out});
        end
    endtask

    task automatic test_host_read;
        @(negedge clk);
        host_addr = 8'h40; host_rd_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ifb.wr_en_out, ifb.rd_en_out, ifb.address_out} !== {2'b01, 8'h40}) begin
            n_fail++; $display("FAIL rd_grant: got %h want %h",
                {ifb.wr_en_out, ifb.rd_en_out, ifb.address_out}, {2'b01, 8'h40});
        end
        m_wr_done = 1'b1;
        @(negedge clk);
        m_wr_done = 1'b0;
        n_tests++;
        if (host_ack !== 1'b0) begin
            n_fail++; $display("FAIL rd_ignores_wr_done: got %b want 0", host_ack);
        end
        m_rd_done = 1'b1; m_rd_data = 16'h1234;
        @(negedge clk);
        m_rd_done = 1'b0; m_rd_data = 16'h0000;
        n_tests++;
        if ({host_ack, host_rd_data} !== {1'b1, 16'h1234}) begin
            n_fail++; $display("FAIL rd_ack_data: got %h want %h", {host_ack, host_rd_data}, {1'b1, 16'h1234});
        end
        host_rd_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({host_ack, host_rd_data} !== {1'b0, 16'h1234}) begin
            n_fail++; $display("FAIL rd_data_hold: got %h want %h", {host_ack, host_rd_data}, {1'b0, 16'h1234});
        end
    endtask

    task automatic test_timeout;
        int   cyc;
        logic pre;
        cyc = 0; pre = 1'bx;
        @(negedge clk);
        host_addr = 8'h33; host_wr_data = 16'h0F0F; host_wr_req = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 254) pre = timeout_err;
            if (host_ack) begin cyc = i; break; end
        end
        host_wr_req = 1'b0;
        n_tests++;
        if (cyc !== 255) begin
            n_fail++; $display("FAIL tmo_cycles: got %0d want 255", cyc);
        end
        n_tests++;
        if ({pre, timeout_err, host_rd_data} !== {2'b01, 16'h1234}) begin
            n_fail++; $display("FAIL tmo_err_set: got %h want %h", {pre, timeout_err, host_rd_data}, {2'b01, 16'h1234});
        end
        host_addr = 8'h34; host_rd_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({ifb.rd_en_out, ifb.address_out} !== {1'b1, 8'h34}) begin
            n_fail++; $display("FAIL tmo_back_idle: got %h want %h", {ifb.rd_en_out, ifb.address_out}, {1'b1, 8'h34});
        end
        m_rd_done = 1'b1; m_rd_data = 16'h9999;
        @(negedge clk);
        m_rd_done = 1'b0;
        host_rd_req = 1'b0;
        n_tests++;
        if ({host_ack, host_rd_data, timeout_err} !== {1'b1, 16'h9999, 1'b1}) begin
            n_fail++; $display("FAIL tmo_sticky: got %h want %h", {host_ack, host_rd_data, timeout_err}, {1'b1, 16'h9999, 1'b1});
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        host_addr = 8'h55; host_wr_data = 16'hAAAA; host_wr_req = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ifb.wr_en_out !== 1'b1) begin
            n_fail++; $display("FAIL midrst_grant: got %b want 1", ifb.wr_en_out);
        end
        reset = 1'b1; m_wr_done = 1'b1; host_wr_req = 1'b0;
        #1;
        n_tests++;
        if ({timeout_err, host_ack, ifb.wr_en_out, ifb.address_out, ifb.write_data_out, host_rd_data} !== 43'h0) begin
            n_fail++; $display("FAIL midrst_async: got %h want 0",
                {timeout_err, host_ack, ifb.wr_en_out, ifb.address_out, ifb.write_data_out, host_rd_data});
        end
        @(negedge clk);
        reset = 1'b0; m_wr_done = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({host_ack, ifb.wr_en_out, ifb.rd_en_out} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_no_ack: got %b want 000", {host_ack, ifb.wr_en_out, ifb.rd_en_out});
        end
    endtask

    task automatic test_rebuild_sweep;
        logic [31:0] got;
        @(negedge clk);
        log_s.delete();
        s_rebuild_start = 1'b1;
        @(negedge clk);
        s_rebuild_start = 1'b0;
        n_tests++;
        if (s_rebuild_busy !== 1'b1) begin
            n_fail++; $display("FAIL sweep_busy: got %b want 1", s_rebuild_busy);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!s_rebuild_busy) break;
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({done_s, log_s.size()} !== {32'd1, 32'd8}) begin
            n_fail++; $display("FAIL sweep_counts: got done=%0d ops=%0d want done=1 ops=8", done_s, log_s.size());
        end
        for (int k = 0; k < 8; k++) begin
            got = (k < log_s.size()) ? log_s[k] : 32'hFFFF_FFFF;
            n_tests++;
            if (got !== evs(k[0], 2'(k / 2), k[0] ? 16'hC000 + 16'(k / 2) : 16'h0000)) begin
                n_fail++; $display("FAIL sweep_op%0d: got %h want %h", k, got,
                    evs(k[0], 2'(k / 2), k[0] ? 16'hC000 + 16'(k / 2) : 16'h0000));
            end
        end
        n_tests++;
        if ({s_rebuild_busy, s_rebuild_addr, s_host_ack} !== 4'b0) begin
            n_fail++; $display("FAIL sweep_end: got %b want 0000", {s_rebuild_busy, s_rebuild_addr, s_host_ack});
        end
    endtask

    task automatic test_burst;
        logic [31:0] exp_q[18];
        logic [31:0] got;
        int k;
        k = 0;
        for (int g = 0; g < 3; g++) begin
            for (int h = 0; h < 4; h++) begin exp_q[k] = evb(1'b1, 8'h77, 16'h5555); k++; end
            exp_q[k] = evb(1'b0, 8'(g), 16'h0000); k++;
            exp_q[k] = evb(1'b1, 8'(g), 16'hA000 + 16'(g)); k++;
        end
        @(negedge clk);
        log_b.delete();
        auto_big = 1'b1; rebuild_start = 1'b1;
        @(negedge clk);
        rebuild_start = 1'b0;
        host_addr = 8'h77; host_wr_data = 16'h5555; host_wr_req = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (log_b.size() >= 18) break;
        end
        host_wr_req = 1'b0; rebuild_abort = 1'b1;
        @(negedge clk);
        rebuild_abort = 1'b0;
        for (int j = 0; j < 18; j++) begin
            got = (j < log_b.size()) ? log_b[j] : 32'hFFFF_FFFF;
            n_tests++;
            if (got !== exp_q[j]) begin
                n_fail++; $display("FAIL burst_op%0d: got %h want %h", j, got, exp_q[j]);
            end
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!rebuild_busy) break;
        end
        n_tests++;
        if ({rebuild_busy, rebuild_addr, done_b} !== {1'b0, 8'h00, 32'd0}) begin
            n_fail++; $display("FAIL burst_abort: got busy=%b addr=%h done=%0d want 0 00 0", rebuild_busy, rebuild_addr, done_b);
        end
    endtask

    task automatic test_abort;
        int   d0;
        logic found;
        logic [31:0] last;
        found = 1'b0;
        @(negedge clk);
        log_b.delete();
        d0 = done_b;
        rebuild_start = 1'b1; rebuild_abort = 1'b1;
        @(negedge clk);
        rebuild_start = 1'b0; rebuild_abort = 1'b0;
        n_tests++;
        if (rebuild_busy !== 1'b1) begin
            n_fail++; $display("FAIL start_beats_abort: got %b want 1", rebuild_busy);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifb.rd_en_out && ifb.address_out == 8'h05) begin found = 1'b1; break; end
        end
        rebuild_abort = 1'b1;
        n_tests++;
        if ({found, rebuild_addr} !== {1'b1, 8'h05}) begin
            n_fail++; $display("FAIL abort_reach5: got %h want %h", {found, rebuild_addr}, {1'b1, 8'h05});
        end
        @(negedge clk);
        rebuild_abort = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rebuild_busy) break;
        end
        repeat (4) @(negedge clk);
        last = (log_b.size() > 0) ? log_b[log_b.size() - 1] : 32'hFFFF_FFFF;
        n_tests++;
        if ({last, 32'(log_b.size())} !== {evb(1'b1, 8'h05, 16'hA005), 32'd12}) begin
            n_fail++; $display("FAIL abort_last_op: got %h ops=%0d want %h ops=12", last, log_b.size(), evb(1'b1, 8'h05, 16'hA005));
        end
        n_tests++;
        if ({rebuild_busy, rebuild_addr, 32'(done_b - d0)} !== {1'b0, 8'h00, 32'd0}) begin
            n_fail++; $display("FAIL abort_end: got busy=%b addr=%h dones=%0d want 0 00 0", rebuild_busy, rebuild_addr, done_b - d0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_host_write;
        test_host_read;
        test_timeout;
        test_reset_mid_op;
        test_rebuild_sweep;
        test_burst;
        test_abort;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
